// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
//  Owns the PC and drives instr_mem (1-cycle synchronous read). Tracks the one
//  request in flight and presents fe_instr/fe_pc/fe_valid to the fetch/decode
//  register. Handles stall (hold output), redirect (flush + new PC) and
//  halt/resume.
// Ports:
//  clk, reset          clock; synchronous active-high reset
//  pc_init             PC loaded while reset is high
//  stall               decode cannot accept; freeze the presented output
//  redirect_valid/_pc  flush and restart fetch at redirect_pc (word aligned)
//  halt_req, resume    stop issuing fetches / leave HALT
//  imem_rdata          read data for the address issued on the previous cycle
//  imem_addr, imem_en  instr_mem address (= pc) and read enable
//  fe_instr/pc/valid   instruction presented to decode
//  halted              HALT with nothing left to deliver
//  misalign_err        1-cycle pulse after a redirect with redirect_pc[1:0]!=0
module fetch_ctrl #(
  parameter int XLEN    = 32,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_init,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  input  logic            resume,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_en,
  output logic [XLEN-1:0] fe_instr,
  output logic [XLEN-1:0] fe_pc,
  output logic            fe_valid,
  output logic            halted,
  output logic            misalign_err
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            use_hold_q, use_hold_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            misalign_q, misalign_d;
  logic            issue;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next state: redirect leaves HALT alone but always clears STALL.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (state_q == S_HALT) ? S_HALT : S_RUN;
    end else begin
      case (state_q)
        S_RUN, S_STALL: begin
          if (halt_req)   state_d = S_HALT;
          else if (stall) state_d = S_STALL;
          else            state_d = S_RUN;
        end
        S_HALT: if (resume && !halt_req) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Outputs and datapath next values.
  always_comb begin
    issue = !reset && !redirect_valid && !halt_req && !stall && (state_q != S_HALT);

    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    use_hold_d  = use_hold_q;
    hold_d      = hold_q;
    misalign_d  = 1'b0;

    if (redirect_valid) begin
      pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
      req_valid_d = 1'b0;
      use_hold_d  = 1'b0;
      misalign_d  = |redirect_pc[1:0];
    end else if (issue) begin
      pc_d        = pc_q + XLEN'(PC_STEP);
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      use_hold_d  = 1'b0;
    end else if (!stall) begin
      // Presented output consumed with nothing new issued (halting).
      req_valid_d = 1'b0;
      use_hold_d  = 1'b0;
    end else if (req_valid_q && !use_hold_q) begin
      // First stalled cycle: the RAM output will not persist, capture it.
      hold_d     = imem_rdata;
      use_hold_d = 1'b1;
    end

    imem_addr    = pc_q;
    imem_en      = issue;
    fe_pc        = req_pc_q;
    fe_instr     = use_hold_q ? hold_q : imem_rdata;
    fe_valid     = req_valid_q && !redirect_valid;
    halted       = (state_q == S_HALT) && !req_valid_q;
    misalign_err = misalign_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= pc_init;
      req_valid_q <= 1'b0;
      req_pc_q    <= pc_init;
      use_hold_q  <= 1'b0;
      hold_q      <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      use_hold_q  <= use_hold_d;
      hold_q      <= hold_d;
      misalign_q  <= misalign_d;
    end
  end

endmodule
